// File: rtl/vend_ctrl.sv
// Vending controller: coin credit, one-hot product selection against a price table,
// vend handshake, then change/refund one unit per handshake. Option: VEND_MULTI_EN.
`timescale 1ns/1ps

module vend_ctrl #(
  parameter int                          NUM_SEL     = 4,
  parameter int                          CREDIT_W    = 6,
  parameter logic [NUM_SEL*CREDIT_W-1:0] PRICES      = 24'h1840C3,
  parameter int                          TIMEOUT_CYC = 1000,
  localparam int                         SEL_W       = (NUM_SEL > 1) ? $clog2(NUM_SEL) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          coin_in,
  input  logic [NUM_SEL-1:0]  sel_in,
  input  logic                cancel,
  input  logic                vend_ready,
  input  logic                change_ready,
  output logic                coin_accept,
  output logic                coin_reject,
  output logic [NUM_SEL-1:0]  sel_lamp,
  output logic                sel_deny,
  output logic                vend_valid,
  output logic [SEL_W-1:0]    vend_sel,
  output logic                change_valid,
  output logic [CREDIT_W-1:0] credit
);

  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CREDIT,
    S_VEND,
    S_CHANGE,
    S_REFUND
  } state_e;

  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [SEL_W-1:0]    vend_sel_q, vend_sel_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic                coin_reject_q, coin_reject_d;
  logic                sel_deny_q, sel_deny_d;
  logic                coin_accept_q, coin_accept_d;
  logic                vend_valid_q, vend_valid_d;
  logic                change_valid_q, change_valid_d;
  logic [NUM_SEL-1:0]  sel_lamp_q, sel_lamp_d;

  logic [CREDIT_W-1:0] coin_val;
  logic [CREDIT_W:0]   coin_sum;
  logic                coin_fits;
  logic                sel_one;
  logic [SEL_W-1:0]    sel_idx;
  logic [CREDIT_W-1:0] credit_after_vend;

  function automatic logic [CREDIT_W-1:0] price_of(input int idx);
    return PRICES[idx*CREDIT_W +: CREDIT_W];
  endfunction

  // Reset asserts asynchronously but is released in step with clk.
  logic [1:0] rst_sync_q;
  logic       rst_int_n;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= '0;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_int_n = rst_sync_q[1];

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q        <= S_IDLE;
      credit_q       <= '0;
      vend_sel_q     <= '0;
      timer_q        <= '0;
      coin_reject_q  <= 1'b0;
      sel_deny_q     <= 1'b0;
      coin_accept_q  <= 1'b1;
      vend_valid_q   <= 1'b0;
      change_valid_q <= 1'b0;
      sel_lamp_q     <= '0;
    end else begin
      state_q        <= state_d;
      credit_q       <= credit_d;
      vend_sel_q     <= vend_sel_d;
      timer_q        <= timer_d;
      coin_reject_q  <= coin_reject_d;
      sel_deny_q     <= sel_deny_d;
      coin_accept_q  <= coin_accept_d;
      vend_valid_q   <= vend_valid_d;
      change_valid_q <= change_valid_d;
      sel_lamp_q     <= sel_lamp_d;
    end
  end

  always_comb begin
    // NOTE: every comb output gets a default first, so no path leaves it unassigned (no latch).
    state_d       = state_q;
    credit_d      = credit_q;
    vend_sel_d    = vend_sel_q;
    timer_d       = timer_q;
    coin_reject_d = 1'b0;
    sel_deny_d    = 1'b0;

    unique case (coin_in)
      2'b01:   coin_val = CREDIT_W'(1);
      2'b10:   coin_val = CREDIT_W'(2);
      2'b11:   coin_val = CREDIT_W'(4);
      default: coin_val = '0;
    endcase
    coin_sum  = {1'b0, credit_q} + {1'b0, coin_val};
    coin_fits = !coin_sum[CREDIT_W];

    sel_one = (sel_in != '0) && ((sel_in & (sel_in - NUM_SEL'(1))) == '0);
    sel_idx = '0;
    for (int i = 0; i < NUM_SEL; i++) begin
      if (sel_in[i]) sel_idx = SEL_W'(i);
    end
    credit_after_vend = credit_q - price_of(int'(vend_sel_q));

    unique case (state_q)
      S_IDLE: begin
        sel_deny_d = (sel_in != '0);
        if (coin_in != 2'b00) begin
          if (coin_fits) begin
            credit_d = coin_sum[CREDIT_W-1:0];
            state_d  = S_CREDIT;
            timer_d  = '0;
          end else begin
            coin_reject_d = 1'b1;
          end
        end
      end

      S_CREDIT: begin
        if (cancel) begin
          coin_reject_d = (coin_in != 2'b00);
          state_d       = S_REFUND;
        end else if (sel_in != '0) begin
          coin_reject_d = (coin_in != 2'b00);
          if (sel_one && credit_q >= price_of(int'(sel_idx))) begin
            vend_sel_d = sel_idx;
            state_d    = S_VEND;
          end else begin
            sel_deny_d = 1'b1;
            timer_d    = '0;
          end
        end else if (coin_in != 2'b00 && coin_fits) begin
          credit_d = coin_sum[CREDIT_W-1:0];
          timer_d  = '0;
        end else begin
          // An overflowing coin is returned and does not count as activity.
          coin_reject_d = (coin_in != 2'b00);
          if (timer_q == TMR_W'(TIMEOUT_CYC - 1)) state_d = S_REFUND;
          else                                    timer_d = timer_q + TMR_W'(1);
        end
      end

      S_VEND: begin
        coin_reject_d = (coin_in != 2'b00);
        if (vend_valid_q && vend_ready) begin
          credit_d = credit_after_vend;
          if (credit_after_vend == '0) begin
            state_d = S_IDLE;
          end else begin
`ifdef VEND_MULTI_EN
            state_d = S_CREDIT;
            timer_d = '0;
`else
            state_d = S_CHANGE;
`endif
          end
        end
      end

      S_CHANGE, S_REFUND: begin
        coin_reject_d = (coin_in != 2'b00);
        if (change_valid_q && change_ready) begin
          credit_d = credit_q - CREDIT_W'(1);
          if (credit_q == CREDIT_W'(1)) state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Moore outputs are derived from the next state so they register alongside it.
  always_comb begin
    coin_accept_d  = (state_d == S_IDLE) || (state_d == S_CREDIT);
    vend_valid_d   = (state_d == S_VEND);
    change_valid_d = ((state_d == S_CHANGE) || (state_d == S_REFUND)) && (credit_d != '0);
    sel_lamp_d     = '0;
    if (state_d == S_CREDIT) begin
      for (int i = 0; i < NUM_SEL; i++) begin
        sel_lamp_d[i] = (credit_d >= price_of(i));
      end
    end
  end

  assign coin_accept  = coin_accept_q;
  assign coin_reject  = coin_reject_q;
  assign sel_lamp     = sel_lamp_q;
  assign sel_deny     = sel_deny_q;
  assign vend_valid   = vend_valid_q;
  assign vend_sel     = vend_sel_q;
  assign change_valid = change_valid_q;
  assign credit       = credit_q;

endmodule

// File: tb/tb_vend_ctrl.sv
// Self-checking bench for vend_ctrl: table of per-cycle vectors with expected outputs
// queued on drive and compared one clock later, plus hand-written reset sequences.
`timescale 1ns/1ps

module tb_vend_ctrl;

  localparam int TO_CYC = 30;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [1:0] coin_in = '0;
  logic [3:0] sel_in = '0;
  logic       cancel = 1'b0;
  logic       vend_ready = 1'b0;
  logic       change_ready = 1'b0;
  logic       coin_accept, coin_reject, sel_deny, vend_valid, change_valid;
  logic [3:0] sel_lamp;
  logic [1:0] vend_sel;
  logic [5:0] credit;

  vend_ctrl #(
    .NUM_SEL    (4),
    .CREDIT_W   (6),
    .PRICES     (24'h1840C3),
    .TIMEOUT_CYC(TO_CYC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .coin_in     (coin_in),
    .sel_in      (sel_in),
    .cancel      (cancel),
    .vend_ready  (vend_ready),
    .change_ready(change_ready),
    .coin_accept (coin_accept),
    .coin_reject (coin_reject),
    .sel_lamp    (sel_lamp),
    .sel_deny    (sel_deny),
    .vend_valid  (vend_valid),
    .vend_sel    (vend_sel),
    .change_valid(change_valid),
    .credit      (credit)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] credit;
    logic       acc, rej, deny, vv;
    logic [1:0] vs;
    logic       cv;
    logic [3:0] lamp;
  } exp_t;

  typedef struct {
    logic [1:0] coin;
    logic [3:0] sel;
    logic       cancel, vr, cr;
    exp_t       e;
  } vec_t;

  vec_t vecs[$];
  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   mon_idx = 0;
  logic [1:0] vs_now = 2'd0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic add(input logic [1:0] coin, input logic [3:0] sel, input logic cn,
                     input logic vr, input logic cr, input logic [5:0] cred,
                     input logic acc, input logic rej, input logic deny, input logic vv,
                     input logic [1:0] vs, input logic cv, input logic [3:0] lamp);
    vec_t v;
    v.coin = coin; v.sel = sel; v.cancel = cn; v.vr = vr; v.cr = cr;
    v.e.credit = cred; v.e.acc = acc; v.e.rej = rej; v.e.deny = deny;
    v.e.vv = vv; v.e.vs = vs; v.e.cv = cv; v.e.lamp = lamp;
    vecs.push_back(v);
  endtask

  // Lamp pattern for prices {6,4,3,3} (bit 3 down to bit 0) while in CREDIT.
  function automatic logic [3:0] lamp_of(input int c);
    return {c >= 6, c >= 4, c >= 3, c >= 3};
  endfunction

  // Scoreboard: pop one expectation per clock, 1 ns after the active edge.
  initial begin
    forever begin
      exp_t e;
      @(posedge clk);
      #1;
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check($sformatf("v%0d credit", mon_idx), 32'(credit), 32'(e.credit));
        check($sformatf("v%0d coin_accept", mon_idx), 32'(coin_accept), 32'(e.acc));
        check($sformatf("v%0d coin_reject", mon_idx), 32'(coin_reject), 32'(e.rej));
        check($sformatf("v%0d sel_deny", mon_idx), 32'(sel_deny), 32'(e.deny));
        check($sformatf("v%0d vend_valid", mon_idx), 32'(vend_valid), 32'(e.vv));
        check($sformatf("v%0d vend_sel", mon_idx), 32'(vend_sel), 32'(e.vs));
        check($sformatf("v%0d change_valid", mon_idx), 32'(change_valid), 32'(e.cv));
        check($sformatf("v%0d sel_lamp", mon_idx), 32'(sel_lamp), 32'(e.lamp));
        mon_idx++;
      end
    end
  end

  task automatic idle_inputs();
    coin_in = '0; sel_in = '0; cancel = 1'b0; vend_ready = 1'b0; change_ready = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " credit"}, 32'(credit), 32'd0);
    check({tag, " coin_accept"}, 32'(coin_accept), 32'd1);
    check({tag, " coin_reject"}, 32'(coin_reject), 32'd0);
    check({tag, " sel_deny"}, 32'(sel_deny), 32'd0);
    check({tag, " vend_valid"}, 32'(vend_valid), 32'd0);
    check({tag, " vend_sel"}, 32'(vend_sel), 32'd0);
    check({tag, " change_valid"}, 32'(change_valid), 32'd0);
    check({tag, " sel_lamp"}, 32'(sel_lamp), 32'd0);
  endtask

  initial begin
    // Selection while IDLE is refused.
    add(2'b00, 4'b0010, 0, 0, 0,  0, 1, 0, 1, 0, 2'd0, 0, 4'b0000);
    add(2'b00, 4'b0000, 0, 0, 0,  0, 1, 0, 0, 0, 2'd0, 0, 4'b0000);
    // 1 + 2 units, buy product 0 (price 3): exact credit, straight back to IDLE.
    add(2'b01, 4'b0000, 0, 0, 0,  1, 1, 0, 0, 0, 2'd0, 0, 4'b0000);
    add(2'b10, 4'b0000, 0, 0, 0,  3, 1, 0, 0, 0, 2'd0, 0, 4'b0011);
    add(2'b00, 4'b0001, 0, 0, 0,  3, 0, 0, 0, 1, 2'd0, 0, 4'b0000);
    add(2'b00, 4'b0000, 0, 1, 0,  0, 1, 0, 0, 0, 2'd0, 0, 4'b0000);
    add(2'b00, 4'b0000, 0, 0, 0,  0, 1, 0, 0, 0, 2'd0, 0, 4'b0000);
`ifndef VEND_MULTI_EN
    // 4 units, buy product 0: one unit of change, stalls honoured; VEND ignores cancel/sel.
    add(2'b11, 4'b0000, 0, 0, 0,  4, 1, 0, 0, 0, 2'd0, 0, 4'b0111);
    add(2'b00, 4'b0001, 0, 0, 0,  4, 0, 0, 0, 1, 2'd0, 0, 4'b0000);
    add(2'b01, 4'b0010, 1, 0, 0,  4, 0, 1, 0, 1, 2'd0, 0, 4'b0000);
    add(2'b00, 4'b0000, 0, 1, 0,  1, 0, 0, 0, 0, 2'd0, 1, 4'b0000);
    add(2'b00, 4'b0000, 0, 0, 0,  1, 0, 0, 0, 0, 2'd0, 1, 4'b0000);
    add(2'b00, 4'b0000, 0, 0, 1,  0, 1, 0, 0, 0, 2'd0, 0, 4'b0000);
    add(2'b00, 4'b0000, 0, 0, 0,  0, 1, 0, 0, 0, 2'd0, 0, 4'b0000);
    // Insufficient credit and multi-hot selections are refused; then buy product 2.
    add(2'b10, 4'b0000, 0, 0, 0,  2, 1, 0, 0, 0, 2'd0, 0, 4'b0000);
    add(2'b00, 4'b1000, 0, 0, 0,  2, 1, 0, 1, 0, 2'd0, 0, 4'b0000);
    add(2'b00, 4'b0000, 0, 0, 0,  2, 1, 0, 0, 0, 2'd0, 0, 4'b0000);
    add(2'b11, 4'b0000, 0, 0, 0,  6, 1, 0, 0, 0, 2'd0, 0, 4'b1111);
    add(2'b00, 4'b0011, 0, 0, 0,  6, 1, 0, 1, 0, 2'd0, 0, 4'b1111);
    add(2'b00, 4'b0000, 0, 0, 0,  6, 1, 0, 0, 0, 2'd0, 0, 4'b1111);
    add(2'b00, 4'b0100, 0, 0, 0,  6, 0, 0, 0, 1, 2'd2, 0, 4'b0000);
    add(2'b00, 4'b0000, 0, 1, 0,  2, 0, 0, 0, 0, 2'd2, 1, 4'b0000);
    add(2'b00, 4'b0000, 0, 0, 1,  1, 0, 0, 0, 0, 2'd2, 1, 4'b0000);
    add(2'b00, 4'b0000, 0, 0, 1,  0, 1, 0, 0, 0, 2'd2, 0, 4'b0000);
    vs_now = 2'd2;
`else
    // Credit 8: buy product 2 (4), then product 0 (3), then cancel refunds the last unit.
    add(2'b11, 4'b0000, 0, 0, 0,  4, 1, 0, 0, 0, 2'd0, 0, 4'b0111);
    add(2'b11, 4'b0000, 0, 0, 0,  8, 1, 0, 0, 0, 2'd0, 0, 4'b1111);
    add(2'b00, 4'b0100, 0, 0, 0,  8, 0, 0, 0, 1, 2'd2, 0, 4'b0000);
    add(2'b00, 4'b0000, 0, 1, 0,  4, 1, 0, 0, 0, 2'd2, 0, 4'b0111);
    add(2'b00, 4'b0001, 0, 0, 0,  4, 0, 0, 0, 1, 2'd0, 0, 4'b0000);
    add(2'b00, 4'b0000, 0, 1, 0,  1, 1, 0, 0, 0, 2'd0, 0, 4'b0000);
    add(2'b00, 4'b0000, 1, 0, 0,  1, 0, 0, 0, 0, 2'd0, 1, 4'b0000);
    add(2'b00, 4'b0000, 0, 0, 1,  0, 1, 0, 0, 0, 2'd0, 0, 4'b0000);
    vs_now = 2'd0;
`endif
    // Credit 5, cancel with a coin in the same cycle: coin returned, 5 units refunded.
    add(2'b11, 4'b0000, 0, 0, 0,  4, 1, 0, 0, 0, vs_now, 0, 4'b0111);
    add(2'b01, 4'b0000, 0, 0, 0,  5, 1, 0, 0, 0, vs_now, 0, 4'b0111);
    add(2'b01, 4'b0000, 1, 0, 0,  5, 0, 1, 0, 0, vs_now, 1, 4'b0000);
    add(2'b00, 4'b0000, 0, 0, 1,  4, 0, 0, 0, 0, vs_now, 1, 4'b0000);
    add(2'b00, 4'b0000, 0, 0, 0,  4, 0, 0, 0, 0, vs_now, 1, 4'b0000);
    add(2'b00, 4'b0000, 0, 0, 1,  3, 0, 0, 0, 0, vs_now, 1, 4'b0000);
    add(2'b10, 4'b0000, 0, 0, 1,  2, 0, 1, 0, 0, vs_now, 1, 4'b0000);
    add(2'b00, 4'b0000, 0, 0, 0,  2, 0, 0, 0, 0, vs_now, 1, 4'b0000);
    add(2'b00, 4'b0000, 0, 0, 1,  1, 0, 0, 0, 0, vs_now, 1, 4'b0000);
    add(2'b00, 4'b0000, 0, 0, 1,  0, 1, 0, 0, 0, vs_now, 0, 4'b0000);
    // Fill to 62, overflowing coin rejected, timeout to REFUND, full payout.
    for (int k = 1; k <= 15; k++)
      add(2'b11, 4'b0000, 0, 0, 0, 6'(4*k), 1, 0, 0, 0, vs_now, 0, lamp_of(4*k));
    add(2'b10, 4'b0000, 0, 0, 0, 6'd62, 1, 0, 0, 0, vs_now, 0, 4'b1111);
    add(2'b11, 4'b0000, 0, 0, 0, 6'd62, 1, 1, 0, 0, vs_now, 0, 4'b1111);
    for (int k = 0; k < TO_CYC - 2; k++)
      add(2'b00, 4'b0000, 0, 0, 0, 6'd62, 1, 0, 0, 0, vs_now, 0, 4'b1111);
    add(2'b00, 4'b0000, 0, 0, 0, 6'd62, 0, 0, 0, 0, vs_now, 1, 4'b0000);
    for (int k = 61; k >= 0; k--)
      add(2'b00, 4'b0000, 0, 0, 1, 6'(k), (k == 0), 0, 0, 0, vs_now, (k != 0), 4'b0000);

    // Reset state, checked while reset is held.
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_reset_outputs("reset");
    @(negedge clk) rst_n = 1'b1;
    repeat (4) @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      coin_in = vecs[i].coin; sel_in = vecs[i].sel; cancel = vecs[i].cancel;
      vend_ready = vecs[i].vr; change_ready = vecs[i].cr;
      sb_q.push_back(vecs[i].e);
    end
    @(negedge clk) idle_inputs();
    @(posedge clk);
    #2;
    check("scoreboard drained", 32'(sb_q.size()), 32'd0);

    // Reset in the middle of a vend: credit lost, outputs return immediately.
    @(negedge clk) coin_in = 2'b11;
    @(negedge clk) begin coin_in = 2'b00; sel_in = 4'b0001; end
    @(negedge clk) sel_in = 4'b0000;
    check("pre-reset vend_valid", 32'(vend_valid), 32'd1);
    check("pre-reset credit", 32'(credit), 32'd4);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("mid-vend reset");
    @(negedge clk) rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("post-reset credit", 32'(credit), 32'd0);
    check("post-reset coin_accept", 32'(coin_accept), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vend_ctrl.md
# vend_ctrl

Parametrised vending controller: accumulates coin credit, gates one-hot product selections against a per-product price table, hands the vend to a dispenser over a valid/ready handshake, then pays out change or refunds one coin-unit per handshake. Sits between the coin acceptor / keypad front end and the dispenser and changer mechanics; supersedes the fixed 15/20-unit coffee seller.

## Interface
- NUM_SEL, 4, number of products; `sel_in`/`sel_lamp` width.
- CREDIT_W, 6, credit register width in coin units (1 unit = 5 money).
- PRICES, 24'h1840C3, packed NUM_SEL×CREDIT_W price table; product i at [i*CREDIT_W +: CREDIT_W]; default 3,3,4,6 units.
- TIMEOUT_CYC, 1000, idle cycles in CREDIT before auto-refund.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- coin_in  in  2  one-cycle coin code: 00 none, 01 = 1 unit, 10 = 2 units, 11 = 4 units.
- sel_in  in  NUM_SEL  selection request, must be one-hot.
- cancel  in  1  refund request.
- vend_ready  in  1  dispenser accepts vend.
- change_ready  in  1  changer released one unit.
- coin_accept  out  1  acceptor enabled (IDLE/CREDIT).
- coin_reject  out  1  one-cycle pulse: coin returned.
- sel_lamp  out  NUM_SEL  bit i high when credit ≥ price i in CREDIT.
- sel_deny  out  1  one-cycle pulse: selection refused.
- vend_valid  out  1  vend request.
- vend_sel  out  $clog2(NUM_SEL)  product index, stable while vend_valid.
- change_valid  out  1  unit to pay out (CHANGE/REFUND).
- credit  out  CREDIT_W  current credit.

## Operation
- States: IDLE, CREDIT, VEND, CHANGE, REFUND. All outputs registered.
- IDLE/CREDIT: nonzero coin_in adds value; if sum > 2^CREDIT_W−1, coin_reject pulses, credit unchanged. First accepted coin IDLE→CREDIT.
- CREDIT priority per cycle: cancel > selection > coin. Cancel → REFUND; a coin in the same cycle is rejected.
- Selection: exactly one bit set and credit ≥ price → latch index, VEND; coin same cycle rejected. Multi-hot, or insufficient credit → sel_deny, stay. Selection in IDLE → sel_deny.
- VEND: vend_valid=1 until vend_valid&vend_ready; then credit −= price; credit 0 → IDLE, else → CHANGE. cancel, sel_in ignored; coins rejected.
- CHANGE/REFUND: change_valid=1 while credit>0; each change_ready cycle credit −=1; reaching 0 → IDLE. Coins rejected, cancel ignored.
- Timeout: counter in CREDIT, cleared by accepted coin, sel_deny, or state entry; at TIMEOUT_CYC−1 → REFUND.

## Timing
- Reset (async assert, sync deassert inside block): state IDLE, credit 0, vend_valid 0, change_valid 0, coin_reject 0, sel_deny 0, sel_lamp 0, vend_sel 0, coin_accept 1.
- Coin at edge n: credit visible n+1; sel_lamp updated same edge as credit.
- Selection at edge n: vend_valid high from n+1; min vend-to-next-state 1 cycle after handshake.
- Change: max one unit per cycle; change_valid drops the cycle after the last unit's handshake.
- Reset mid-VEND/CHANGE: credit lost, outputs to reset values immediately.

## Configuration
- VEND_MULTI_EN defined: after vend handshake with credit>0 return to CREDIT (timeout restarted) for further purchases; change only via cancel or timeout.
- Undefined: remaining credit always paid out via CHANGE, as above.

## Test plan
- Coins 01,10 (credit 3), sel_in=0001 -> vend_valid, vend_sel=0; vend_ready -> credit 0, IDLE, no change_valid.
- Coin 11 (4), sel_in=0100? no: sel_in=0001 -> vend; handshake -> CHANGE, exactly 1 change_ready handshake, credit 0.
- Credit 2, sel_in=1000 -> sel_deny pulse, stay CREDIT; sel_in=0011 at credit 6 -> sel_deny.
- Credit 5, cancel with coin 01 same cycle -> coin_reject, REFUND, 5 unit handshakes with change_ready stalls honoured.
- Credit 62, coin 11 -> coin_reject, credit stays 62; TIMEOUT_CYC idle cycles -> REFUND.
- VEND_MULTI_EN: credit 8, buy product 2 -> CREDIT with 4; buy product 0 -> credit 1; cancel -> 1 unit refunded.
